// File: rtl/sort4_ctrl_pkg.sv
// Shared definitions for the bubble-sort sequencer: FSM state encoding,
// element width and the swap-counter width helper.
package sort4_ctrl_pkg;

    localparam int W = 4;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        CMP  = 3'd1,
        SWAP = 3'd2,
        ADV  = 3'd3,
        DONE = 3'd4
    } state_t;

    // Bits needed to count up to the worst-case N*(N-1)/2 swaps.
    function automatic int cw_of(input int n);
        return $clog2(n * (n - 1) / 2 + 1);
    endfunction

endpackage

// File: rtl/sort4_ctrl_cmp.sv
// Shared 4-bit magnitude comparator cell: exactly one of eq/gt/lt is high.
module sort4_ctrl_cmp
    import sort4_ctrl_pkg::*;
(
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         eq,
    output logic         gt,
    output logic         lt
);

    always_comb begin
        eq = (a == b);
        gt = (a > b);
        lt = (a < b);
    end

endmodule

// File: rtl/sort4_ctrl.sv
// Bubble-sort sequencer for N 4-bit elements built around a single shared
// comparator, with early exit once a pass completes without swaps.
module sort4_ctrl
    import sort4_ctrl_pkg::*;
#(
    parameter int N  = 4,
    parameter int CW = cw_of(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            desc,
    input  logic [W*N-1:0]  din,
    output logic            busy,
    output logic            done,
    output logic [W*N-1:0]  dout,
    output logic [CW-1:0]   swap_cnt
);

    localparam int IW = $clog2(N);

    state_t        state;
    state_t        next_state;
    logic [W-1:0]  r [N];
    logic [IW-1:0] pass;
    logic [IW-1:0] j;
    logic [IW-1:0] jn;
    logic [IW-1:0] last_j;
    logic          swapped;
    logic          desc_q;
    logic          at_end;
    logic          last_pass;
    logic          cmp_eq;
    logic          cmp_gt;
    logic          cmp_lt;
    logic          swap_cond;

    assign jn        = j + IW'(1);
    assign last_j    = IW'(N - 2) - pass;
    assign at_end    = (j == last_j);
    assign last_pass = (pass == IW'(N - 2));

    sort4_ctrl_cmp u_cmp (
        .a  (r[j]),
        .b  (r[jn]),
        .eq (cmp_eq),
        .gt (cmp_gt),
        .lt (cmp_lt)
    );

    // Equal elements never swap, which keeps the sort stable.
    assign swap_cond = !cmp_eq && (desc_q ? cmp_lt : cmp_gt);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (start) next_state = CMP;
            CMP:  next_state = swap_cond ? SWAP : ADV;
            SWAP: next_state = ADV;
            ADV: begin
                if (at_end && (last_pass || !swapped)) next_state = DONE;
                else                                   next_state = CMP;
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
        done = (state == DONE);
    end

    // Element registers and pass/index bookkeeping; all hold outside their state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < N; k++) r[k] <= '0;
            pass     <= '0;
            j        <= '0;
            swapped  <= 1'b0;
            swap_cnt <= '0;
            desc_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        for (int k = 0; k < N; k++) r[k] <= din[W*k +: W];
                        desc_q   <= desc;
                        pass     <= '0;
                        j        <= '0;
                        swapped  <= 1'b0;
                        swap_cnt <= '0;
                    end
                end
                SWAP: begin
                    r[j]     <= r[jn];
                    r[jn]    <= r[j];
                    swap_cnt <= swap_cnt + CW'(1);
                    swapped  <= 1'b1;
                end
                ADV: begin
                    if (at_end) begin
                        if (!(last_pass || !swapped)) begin
                            pass    <= pass + IW'(1);
                            j       <= '0;
                            swapped <= 1'b0;
                        end
                    end else begin
                        j <= jn;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        dout = '0;
        for (int k = 0; k < N; k++) dout[W*k +: W] = r[k];
    end

endmodule

// File: tb/tb_sort4_ctrl.sv
// Directed, table-driven bench for sort4_ctrl: sort results, swap counts and
// done timing, plus start-while-busy, start-held and mid-sort reset sequences.
module tb_sort4_ctrl;

    logic        clk;
    logic        rst;
    logic        start;
    logic        desc;
    logic [15:0] din;
    logic        busy;
    logic        done;
    logic [15:0] dout;
    logic [2:0]  swap_cnt;

    int nCompared;
    int nMismatched;

    typedef struct {
        string       name;
        logic        desc;
        logic [15:0] din;
        logic [15:0] expDout;
        int          expSwaps;
        int          expDoneCyc;
    } vec_t;

    vec_t vecs [6];

    sort4_ctrl #(.N(4), .CW(3)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .desc     (desc),
        .din      (din),
        .busy     (busy),
        .done     (done),
        .dout     (dout),
        .swap_cnt (swap_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] pack4(input int e0, input int e1, input int e2, input int e3);
        return {4'(e3), 4'(e2), 4'(e1), 4'(e0)};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        nCompared++;
        if (act !== exp) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    // Counts cycles from firstCyc until done is seen at a negedge; optionally
    // hammers start with junk data during cycles 3..10.
    task automatic waitDone(input int firstCyc, input bit disturb, input logic [15:0] noise,
                            output int cyc);
        bit seen;
        seen = 1'b0;
        cyc  = firstCyc;
        while (cyc < firstCyc + 60) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (disturb && cyc >= 3 && cyc <= 10) begin
                start = 1'b1;
                din   = noise;
                desc  = ~desc;
            end else if (disturb) begin
                start = 1'b0;
            end
            @(posedge clk);
            cyc++;
        end
        start = 1'b0;
        checkOutput("done_seen", 32'(seen), 32'd1);
    endtask

    task automatic applyStimulus(input vec_t v, input bit disturb);
        int cyc;
        @(negedge clk);
        din   = v.din;
        desc  = v.desc;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        waitDone(1, disturb, ~v.din, cyc);
        checkOutput({v.name, "_done_cycle"}, 32'(cyc), 32'(v.expDoneCyc));
        checkOutput({v.name, "_dout"}, 32'(dout), 32'(v.expDout));
        checkOutput({v.name, "_swap_cnt"}, 32'(swap_cnt), 32'(v.expSwaps));
        checkOutput({v.name, "_busy_in_done"}, 32'(busy), 32'd1);
        @(negedge clk);
        checkOutput({v.name, "_done_pulse"}, 32'(done), 32'd0);
        checkOutput({v.name, "_idle_busy"}, 32'(busy), 32'd0);
        checkOutput({v.name, "_dout_hold"}, 32'(dout), 32'(v.expDout));
        checkOutput({v.name, "_cnt_hold"}, 32'(swap_cnt), 32'(v.expSwaps));
    endtask

    initial begin
        int cyc;
        nCompared   = 0;
        nMismatched = 0;
        rst   = 1'b1;
        start = 1'b0;
        desc  = 1'b0;
        din   = '0;

        vecs[0] = '{"asc_sorted",  1'b0, pack4(1,2,3,4), pack4(1,2,3,4), 0, 7};
        vecs[1] = '{"asc_reverse", 1'b0, pack4(4,3,2,1), pack4(1,2,3,4), 6, 19};
        vecs[2] = '{"asc_equal",   1'b0, pack4(2,2,1,2), pack4(1,2,2,2), 2, 15};
        vecs[3] = '{"desc_sorted", 1'b1, pack4(1,2,3,4), pack4(4,3,2,1), 6, 19};
        vecs[4] = '{"desc_equal",  1'b1, pack4(2,2,1,2), pack4(2,2,2,1), 1, 12};
        vecs[5] = '{"asc_mixed",   1'b0, pack4(3,1,2,0), pack4(0,1,2,3), 5, 18};

        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_done", 32'(done), 32'd0);
        checkOutput("reset_dout", 32'(dout), 32'd0);
        checkOutput("reset_cnt", 32'(swap_cnt), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 6; i++) applyStimulus(vecs[i], 1'b0);

        // start pulsed with junk while busy must not alter result or timing
        applyStimulus(vecs[1], 1'b1);

        // start held across DONE->IDLE begins a second sort immediately
        @(negedge clk);
        din   = pack4(1,2,3,4);
        desc  = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1 din = pack4(4,3,2,1);
        waitDone(1, 1'b0, 16'h0, cyc);
        start = 1'b1;
        checkOutput("held_first_cycle", 32'(cyc), 32'd7);
        checkOutput("held_first_dout", 32'(dout), 32'(pack4(1,2,3,4)));
        checkOutput("held_first_cnt", 32'(swap_cnt), 32'd0);
        @(negedge clk);
        checkOutput("held_idle_busy", 32'(busy), 32'd0);
        @(negedge clk);
        checkOutput("held_restart_busy", 32'(busy), 32'd1);
        @(posedge clk);
        #1 start = 1'b0;
        waitDone(10, 1'b0, 16'h0, cyc);
        checkOutput("held_second_cycle", 32'(cyc), 32'd27);
        checkOutput("held_second_dout", 32'(dout), 32'(pack4(1,2,3,4)));
        checkOutput("held_second_cnt", 32'(swap_cnt), 32'd6);

        // async reset in cycle 5 of a sort clears everything at once
        @(negedge clk);
        din   = pack4(4,3,2,1);
        desc  = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (5) @(negedge clk);
        checkOutput("pre_reset_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        checkOutput("midrst_busy", 32'(busy), 32'd0);
        checkOutput("midrst_done", 32'(done), 32'd0);
        checkOutput("midrst_dout", 32'(dout), 32'd0);
        checkOutput("midrst_cnt", 32'(swap_cnt), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("post_reset_idle", 32'(busy), 32'd0);
        applyStimulus(vecs[5], 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
